// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB pipeline bus and register-bank write port of the writeback stage
interface wb_stage_if #(parameter int XLEN = 32);
    logic            stall;
    logic            flush;
    logic            mem_valid;
    logic            mem_regwen;
    logic [4:0]      mem_rd;
    logic [1:0]      mem_wbsel;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_alu;
    logic [XLEN-1:0] mem_pc4;
    logic [XLEN-1:0] mem_ldata;
    logic            regWEn;
    logic [4:0]      addr_D;
    logic [XLEN-1:0] data_D;
    logic            wb_valid;
    logic [XLEN-1:0] retire_cnt;
    modport master (
        output stall, flush, mem_valid, mem_regwen, mem_rd, mem_wbsel, mem_funct3,
               mem_alu, mem_pc4, mem_ldata,
        input  regWEn, addr_D, data_D, wb_valid, retire_cnt
    );
    modport slave (
        input  stall, flush, mem_valid, mem_regwen, mem_rd, mem_wbsel, mem_funct3,
               mem_alu, mem_pc4, mem_ldata,
        output regWEn, addr_D, data_D, wb_valid, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load alignment, writeback mux and retire counter
module wb_stage #(
    parameter int XLEN = 32
) (
    input logic     clock,
    input logic     rst,
    wb_stage_if.slave bus
);
    logic            v_q, regwen_q;
    logic [4:0]      rd_q;
    logic [1:0]      wbsel_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] alu_q, pc4_q, ldata_q, cnt_q;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic [XLEN-1:0] ld, data;
    always_ff @(posedge clock) begin
        if (rst) begin
            {v_q, regwen_q, rd_q, wbsel_q, funct3_q} <= '0;
            {alu_q, pc4_q, ldata_q, cnt_q} <= '0;
        end else begin
            if (v_q && !bus.stall) cnt_q <= cnt_q + 1'b1;
            if (!bus.stall) begin
                v_q      <= bus.mem_valid & ~bus.flush;
                regwen_q <= bus.mem_regwen;
                rd_q     <= bus.mem_rd;
                wbsel_q  <= bus.mem_wbsel;
                funct3_q <= bus.mem_funct3;
                alu_q    <= bus.mem_alu;
                pc4_q    <= bus.mem_pc4;
                ldata_q  <= bus.mem_ldata;
            end else if (bus.flush) begin
                v_q <= 1'b0;
            end
        end
    end
    // undefined funct3 encodings fall through to a whole-word load
    always_comb begin
        lb   = 8'(ldata_q >> {alu_q[1:0], 3'b000});
        lh   = alu_q[1] ? ldata_q[31:16] : ldata_q[15:0];
        ld   = funct3_q == 3'b000 ? {{(XLEN-8){lb[7]}}, lb} :
               funct3_q == 3'b001 ? {{(XLEN-16){lh[15]}}, lh} :
               funct3_q == 3'b100 ? {{(XLEN-8){1'b0}}, lb} :
               funct3_q == 3'b101 ? {{(XLEN-16){1'b0}}, lh} : ldata_q;
        data = wbsel_q == 2'd1 ? ld : wbsel_q == 2'd2 ? pc4_q : alu_q;
    end
    assign bus.regWEn     = v_q & regwen_q & (rd_q != 5'd0);
    assign bus.addr_D     = rd_q;
    assign bus.data_D     = data;
    assign bus.wb_valid   = v_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage with directed load/stall/flush/reset/wrap cases
module tb_wb_stage;
    logic clock = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails = 0;
    wb_stage_if #(.XLEN(32)) bus ();
    wb_stage #(.XLEN(32)) dut (.clock(clock), .rst(rst), .bus(bus));
    always #5 clock = ~clock;
    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        v;
        logic [31:0] c;
    } exp_t;
    exp_t        sb[$];
    logic        m_v, m_we;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_pc4, m_ld, m_cnt;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [2:0] f3,
                                             input logic [31:0] alu, pc4, ldw);
        logic [7:0]  b;
        logic [15:0] h;
        b = ldw[8*alu[1:0] +: 8];
        h = alu[1] ? ldw[31:16] : ldw[15:0];
        if (sel == 2'd2) return pc4;
        if (sel != 2'd1) return alu;
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return ldw;
        endcase
    endfunction
    task automatic cycle(input logic r, s, f, v, we, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, pc4, ldw);
        exp_t e, o;
        rst = r; bus.stall = s; bus.flush = f; bus.mem_valid = v; bus.mem_regwen = we;
        bus.mem_rd = rd; bus.mem_wbsel = sel; bus.mem_funct3 = f3;
        bus.mem_alu = alu; bus.mem_pc4 = pc4; bus.mem_ldata = ldw;
        if (r) begin
            {m_v, m_we, m_rd, m_sel, m_f3} = '0;
            {m_alu, m_pc4, m_ld, m_cnt} = '0;
        end else begin
            if (m_v && !s) m_cnt = m_cnt + 1;
            if (!s) begin
                m_v = v && !f; m_we = we; m_rd = rd; m_sel = sel; m_f3 = f3;
                m_alu = alu; m_pc4 = pc4; m_ld = ldw;
            end else if (f) m_v = 1'b0;
        end
        e.we = m_v && m_we && (m_rd != 5'd0);
        e.a  = m_rd;
        e.d  = ref_data(m_sel, m_f3, m_alu, m_pc4, m_ld);
        e.v  = m_v;
        e.c  = m_cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb.pop_front();
            chk("regWEn", {31'd0, bus.regWEn}, {31'd0, o.we});
            chk("addr_D", {27'd0, bus.addr_D}, {27'd0, o.a});
            chk("data_D", bus.data_D, o.d);
            chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, o.v});
            chk("retire_cnt", bus.retire_cnt, o.c);
        end
    endtask
    task automatic nop(input logic s);
        cycle(0, s, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] base;
        cycle(1, 1, 1, 1, 1, 5'd3, 2'd0, 3'd0, 32'hDEAD, 32'h4, 32'h1);
        chk("rst_regWEn", {31'd0, bus.regWEn}, 32'd0);
        chk("rst_data", bus.data_D, 32'd0);
        chk("rst_cnt", bus.retire_cnt, 32'd0);
        cycle(0, 0, 0, 1, 1, 5'd5, 2'd1, 3'b000, 32'h1, 32'h0, 32'h80F17F01);
        chk("lb_off1", bus.data_D, 32'h0000007F);
        cycle(0, 0, 0, 1, 1, 5'd5, 2'd1, 3'b100, 32'h1, 32'h0, 32'h80F17F01);
        chk("lbu_off1", bus.data_D, 32'h0000007F);
        cycle(0, 0, 0, 1, 1, 5'd5, 2'd1, 3'b000, 32'h3, 32'h0, 32'h80F17F01);
        chk("lb_off3", bus.data_D, 32'hFFFFFF80);
        cycle(0, 0, 0, 1, 1, 5'd5, 2'd1, 3'b100, 32'h3, 32'h0, 32'h80F17F01);
        chk("lbu_off3", bus.data_D, 32'h00000080);
        cycle(0, 0, 0, 1, 1, 5'd5, 2'd1, 3'b001, 32'h3, 32'h0, 32'h80F17F01);
        chk("lh_hi", bus.data_D, 32'hFFFF80F1);
        cycle(0, 0, 0, 1, 1, 5'd5, 2'd1, 3'b101, 32'h2, 32'h0, 32'h80F17F01);
        chk("lhu_hi", bus.data_D, 32'h000080F1);
        cycle(0, 0, 0, 1, 1, 5'd5, 2'd1, 3'b111, 32'h2, 32'h0, 32'h80F17F01);
        chk("f3_111", bus.data_D, 32'h80F17F01);
        chk("wb_addr5", {27'd0, bus.addr_D}, 32'd5);
        cycle(0, 0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
        chk("x0_regWEn", {31'd0, bus.regWEn}, 32'd0);
        chk("x0_addr", {27'd0, bus.addr_D}, 32'd0);
        base = m_cnt;
        nop(0);
        chk("x0_counted", bus.retire_cnt, base + 1);
        cycle(0, 0, 0, 1, 1, 5'd7, 2'd2, 3'd0, 32'h55, 32'h104, 32'h0);
        base = m_cnt;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 1, 1, 5'd9, 2'd0, 3'd0, 32'hBAD, 32'hBAD, 32'hBAD);
            chk("stall_we", {31'd0, bus.regWEn}, 32'd1);
            chk("stall_data", bus.data_D, 32'h104);
            chk("stall_cnt", bus.retire_cnt, base);
        end
        nop(0);
        chk("stall_once", bus.retire_cnt, base + 1);
        cycle(0, 0, 0, 1, 1, 5'd4, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
        cycle(0, 1, 1, 1, 1, 5'd4, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
        chk("stflush_v", {31'd0, bus.wb_valid}, 32'd0);
        chk("stflush_hold", bus.data_D, 32'h77);
        cycle(0, 0, 0, 1, 1, 5'd6, 2'd0, 3'd0, 32'h9, 32'h0, 32'h0);
        base = m_cnt;
        cycle(0, 0, 1, 1, 1, 5'd6, 2'd0, 3'd0, 32'h9, 32'h0, 32'h0);
        chk("flush_counts", bus.retire_cnt, base + 1);
        chk("flush_v", {31'd0, bus.wb_valid}, 32'd0);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
        cycle(0, 0, 0, 1, 1, 5'd8, 2'd0, 3'd0, 32'h42, 32'h0, 32'h0);
        cycle(0, 1, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        cycle(1, 1, 0, 1, 1, 5'd8, 2'd0, 3'd0, 32'h42, 32'h0, 32'h0);
        chk("rststall_we", {31'd0, bus.regWEn}, 32'd0);
        chk("rststall_v", {31'd0, bus.wb_valid}, 32'd0);
        chk("rststall_cnt", bus.retire_cnt, 32'd0);
        cycle(0, 0, 0, 1, 0, 5'd1, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        nop(0);
        chk("wrap", bus.retire_cnt, 32'h0000_0000);
        nop(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
